// File: rtl/argon_alu_unit.sv
// Argon execute unit: captures A/B/opcode from the shared bus, runs
// single-cycle ALU ops or bit-serial shifts, and drives the result back.
module argon_alu_unit #(
  parameter int WIDTH = 16
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  input  logic             i_latchA,
  input  logic             i_latchB,
  input  logic             i_latchOp,
  input  logic             i_start,
  input  logic             i_outputResult,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic [3:0]       o_flags
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_ADC = 4'd1,
    OP_SUB = 4'd2,
    OP_SBB = 4'd3,
    OP_CMP = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6,
    OP_XOR = 4'd7,
    OP_NOT = 4'd8,
    OP_SHL = 4'd9,
    OP_SHR = 4'd10,
    OP_SAR = 4'd11
  } opcode_t;

  state_t           state, stateNext;
  logic [WIDTH-1:0] regA, regB, work, result;
  logic [3:0]       opcode, count, flags;

  logic             isShift;
  logic [3:0]       shAmt;
  logic [WIDTH-1:0] addB;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] aluRes;
  logic             aluC, aluV;
  logic [WIDTH-1:0] workNext;
  logic             shiftOut;

  assign isShift = (opcode == OP_SHL) || (opcode == OP_SHR) || (opcode == OP_SAR);
  assign shAmt   = regB[3:0];

  // Single-cycle ALU; subtraction is A + ~B + cin so carry means "no borrow".
  always_comb begin
    addB   = regB;
    cin    = 1'b0;
    aluRes = regB;
    aluC   = 1'b0;
    aluV   = 1'b0;
    case (opcode)
      OP_ADC:         cin = flags[1];
      OP_SUB, OP_CMP: begin addB = ~regB; cin = 1'b1; end
      OP_SBB:         begin addB = ~regB; cin = flags[1]; end
      default:        ;
    endcase
    sum = {1'b0, regA} + {1'b0, addB} + {{WIDTH{1'b0}}, cin};
    case (opcode)
      OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_CMP: begin
        aluRes = sum[WIDTH-1:0];
        aluC   = sum[WIDTH];
        aluV   = (regA[WIDTH-1] == addB[WIDTH-1]) && (sum[WIDTH-1] != regA[WIDTH-1]);
      end
      OP_AND:  aluRes = regA & regB;
      OP_OR:   aluRes = regA | regB;
      OP_XOR:  aluRes = regA ^ regB;
      OP_NOT:  aluRes = ~regA;
      default: aluRes = regB;
    endcase
  end

  // One shift step of the work register and the bit that falls off.
  always_comb begin
    workNext = work;
    shiftOut = 1'b0;
    case (opcode)
      OP_SHL: begin
        workNext = {work[WIDTH-2:0], 1'b0};
        shiftOut = work[WIDTH-1];
      end
      OP_SHR: begin
        workNext = {1'b0, work[WIDTH-1:1]};
        shiftOut = work[0];
      end
      default: begin
        workNext = {work[WIDTH-1], work[WIDTH-1:1]};
        shiftOut = work[0];
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) state <= IDLE;
    else         state <= stateNext;
  end

  // Next-state logic; start is ignored while shifting.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE, DONE: begin
        if (i_start) begin
          if (isShift && (shAmt != 4'd0)) stateNext = SHIFT;
          else                            stateNext = DONE;
        end
      end
      SHIFT:   if (count == 4'd1) stateNext = DONE;
      default: stateNext = IDLE;
    endcase
  end

  // Operand capture, execution and shift datapath.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      regA   <= '0;
      regB   <= '0;
      opcode <= '0;
      work   <= '0;
      count  <= '0;
      result <= '0;
      flags  <= '0;
    end else begin
      if (i_valid && (state != SHIFT)) begin
        if (i_latchOp)     opcode <= i_data[3:0];
        else if (i_latchA) regA   <= i_data;
        else if (i_latchB) regB   <= i_data;
      end
      case (state)
        IDLE, DONE: begin
          if (i_start) begin
            if (isShift) begin
              if (shAmt == 4'd0) begin
                result <= regA;
                flags  <= {(regA == '0), regA[WIDTH-1], 1'b0, 1'b0};
              end else begin
                work  <= regA;
                count <= shAmt;
              end
            end else begin
              if (opcode != OP_CMP) result <= aluRes;
              flags <= {(aluRes == '0), aluRes[WIDTH-1], aluC, aluV};
            end
          end
        end
        SHIFT: begin
          work  <= workNext;
          count <= count - 4'd1;
          if (count == 4'd1) begin
            result <= workNext;
            flags  <= {(workNext == '0), workNext[WIDTH-1], shiftOut, 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy  = (state == SHIFT);
  assign o_done  = (state == DONE);
  assign o_valid = i_outputResult && (state == DONE);
  assign o_data  = o_valid ? result : '0;
  assign o_flags = flags;

endmodule

// File: tb/tb_argon_alu_unit.sv
// Scoreboard bench for argon_alu_unit: directed cases plus random ops
// checked against an integer-arithmetic reference model.
module tb_argon_alu_unit;

  logic        i_Clk = 1'b0;
  logic        i_Reset;
  logic [15:0] i_data;
  logic        i_valid, i_latchA, i_latchB, i_latchOp, i_start, i_outputResult;
  logic [15:0] o_data;
  logic        o_valid, o_busy, o_done;
  logic [3:0]  o_flags;

  argon_alu_unit #(.WIDTH(16)) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_data(i_data), .i_valid(i_valid),
    .i_latchA(i_latchA), .i_latchB(i_latchB), .i_latchOp(i_latchOp),
    .i_start(i_start), .i_outputResult(i_outputResult),
    .o_data(o_data), .o_valid(o_valid), .o_busy(o_busy), .o_done(o_done),
    .o_flags(o_flags)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct { string name; logic [19:0] exp; } sb_t;
  typedef struct { string name; int act; int exp; } chk_t;
  sb_t  sbQ[$];
  chk_t chkQ[$];
  int   passCount = 0;
  int   checkCount = 0;

  // Model state
  logic [15:0] mA, mB, mRes;
  logic [3:0]  mOp, mFlags;

  // Monitor: pops the scoreboard whenever the unit presents a result,
  // and evaluates sampled status observations queued by the stimulus.
  always @(negedge i_Clk) begin
    sb_t  e;
    chk_t c;
    if (o_valid) begin
      checkCount++;
      if (sbQ.size() == 0) begin
        $display("FAIL unexpected_valid: got data=0x%04h flags=0x%0h with no pending expectation", o_data, o_flags);
      end else begin
        e = sbQ.pop_front();
        if ({o_flags, o_data} === e.exp) passCount++;
        else $display("FAIL %s: got flags=0x%0h data=0x%04h expected flags=0x%0h data=0x%04h",
                      e.name, o_flags, o_data, e.exp[19:16], e.exp[15:0]);
      end
    end
    while (chkQ.size() > 0) begin
      c = chkQ.pop_front();
      checkCount++;
      if (c.act == c.exp) passCount++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, c.act, c.exp);
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Reference: plain integer arithmetic on the opcode rules.
  function automatic logic [19:0] refOp(input logic [3:0] op, input int a, input int b,
                                        input int cin, input int oldRes);
    int sa, sb, s, ss, res, k, c, v, ci;
    logic z, n;
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    k = b % 16;
    c = 0; v = 0; res = 0;
    case (op)
      4'd0, 4'd1: begin
        ci = (op == 4'd1) ? cin : 0;
        s = a + b + ci; res = s % 65536; c = s / 65536;
        ss = sa + sb + ci; v = int'(ss > 32767 || ss < -32768);
      end
      4'd2, 4'd3, 4'd4: begin
        ci = (op == 4'd3) ? 1 - cin : 0;
        s = a - b - ci; c = int'(s >= 0); res = (s + 65536) % 65536;
        ss = sa - sb - ci; v = int'(ss > 32767 || ss < -32768);
      end
      4'd5: res = a & b;
      4'd6: res = a | b;
      4'd7: res = a ^ b;
      4'd8: res = 65535 - a;
      4'd9: begin
        res = (a << k) & 65535;
        c = (k > 0) ? ((a >> (16 - k)) & 1) : 0;
      end
      4'd10: begin
        res = a >> k;
        c = (k > 0) ? ((a >> (k - 1)) & 1) : 0;
      end
      4'd11: begin
        res = (sa >>> k) & 65535;
        c = (k > 0) ? ((a >> (k - 1)) & 1) : 0;
      end
      default: res = b;
    endcase
    z = (res == 0);
    n = (res >= 32768);
    if (op == 4'd4) res = oldRes;
    return {z, n, c[0], v[0], res[15:0]};
  endfunction

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    chkQ.push_back('{name, act, exp});
  endtask

  task automatic clearIn();
    i_valid = 0; i_latchA = 0; i_latchB = 0; i_latchOp = 0;
    i_start = 0; i_outputResult = 0; i_data = '0;
  endtask

  task automatic latch(input logic v, input logic lo, input logic la, input logic lb,
                       input logic [15:0] d);
    i_valid = v; i_latchOp = lo; i_latchA = la; i_latchB = lb; i_data = d;
    tick();
    clearIn();
    if (v) begin
      if (lo)      mOp = d[3:0];
      else if (la) mA = d;
      else if (lb) mB = d;
    end
  endtask

  task automatic requestOut(input string name, input logic [19:0] exp);
    i_outputResult = 1;
    sbQ.push_back('{name, exp});
    tick();
    i_outputResult = 0;
  endtask

  // Start the latched op (optionally re-latching A on the same edge), wait
  // for completion, and optionally disturb the unit mid-shift.
  task automatic runOp(input string name, input bit latchWithStart, input logic [15:0] newA,
                       input int disturbAt);
    logic [19:0] exp;
    int expBusy, busyCnt, n;
    exp = refOp(mOp, int'(mA), int'(mB), int'(mFlags[1]), int'(mRes));
    expBusy = (mOp >= 4'd9 && mOp <= 4'd11) ? int'(mB[3:0]) : 0;
    i_start = 1;
    if (latchWithStart) begin i_valid = 1; i_latchA = 1; i_data = newA; end
    tick();
    clearIn();
    if (latchWithStart) mA = newA;
    busyCnt = 0; n = 0;
    while (!o_done && n < 40) begin
      if (o_busy) busyCnt++;
      if (n == disturbAt) begin
        i_valid = 1; i_latchA = 1; i_data = 16'h1111; i_start = 1;
      end
      tick();
      clearIn();
      n++;
    end
    check({name, "_done"}, int'(o_done), 1);
    check({name, "_busy"}, busyCnt, expBusy);
    mRes = exp[15:0];
    mFlags = exp[19:16];
    check({name, "_flags"}, int'(o_flags), int'(mFlags));
    requestOut(name, {mFlags, mRes});
  endtask

  task automatic setup(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
    latch(1, 0, 1, 0, a);
    latch(1, 0, 0, 1, b);
    latch(1, 1, 0, 0, {12'h000, op});
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [3:0]  rop;
    int order;
    clearIn();
    mA = '0; mB = '0; mRes = '0; mOp = '0; mFlags = '0;
    i_Reset = 1;
    tick(); tick();
    check("rst_data",  int'(o_data), 0);
    check("rst_valid", int'(o_valid), 0);
    check("rst_busy",  int'(o_busy), 0);
    check("rst_done",  int'(o_done), 0);
    check("rst_flags", int'(o_flags), 0);
    i_Reset = 0;
    tick();

    // Output request while idle is not honoured.
    i_outputResult = 1;
    #1;
    check("idle_valid", int'(o_valid), 0);
    check("idle_data",  int'(o_data), 0);
    tick();
    i_outputResult = 0;

    // Signed overflow on ADD.
    setup(16'h7FFF, 16'h0001, 4'd0);
    runOp("add_ovf", 0, '0, -1);
    requestOut("add_ovf_const", {4'b0101, 16'h8000});

    // SUB with borrow; a latch without i_valid must be ignored.
    setup(16'h0003, 16'h0005, 4'd2);
    latch(0, 0, 0, 1, 16'h7777);
    runOp("sub", 0, '0, -1);
    requestOut("sub_const", {4'b0100, 16'hFFFE});

    // CMP leaves the result register alone.
    setup(16'h1234, 16'h1234, 4'd4);
    runOp("cmp", 0, '0, -1);
    requestOut("cmp_const", {4'b1010, 16'hFFFE});

    // Latch priority: op wins over A and B.
    latch(1, 1, 1, 1, 16'h0007);
    runOp("xor_prio", 0, '0, -1);
    requestOut("xor_prio_const", {4'b1000, 16'h0000});
    // Re-latch in DONE does not disturb the held result.
    latch(1, 0, 1, 0, 16'hFFFF);
    requestOut("done_hold", {4'b1000, 16'h0000});

    // Arithmetic shift right by 4.
    setup(16'h8001, 16'h0004, 4'd11);
    runOp("sar4", 0, '0, -1);
    requestOut("sar4_const", {4'b0100, 16'hF800});

    // Shift by zero completes in one edge.
    setup(16'h8001, 16'h0000, 4'd9);
    runOp("shl0", 0, '0, -1);
    requestOut("shl0_const", {4'b0100, 16'h8001});

    // 15-bit SHR with a latch and a start injected mid-shift.
    setup(16'hC000, 16'h000F, 4'd10);
    runOp("shr15_disturb", 0, '0, 3);
    requestOut("shr15_const", {4'b0010, 16'h0001});
    latch(1, 1, 0, 0, 16'h0008);
    runOp("not_after_shift", 0, '0, -1);

    // Carry chain into ADC.
    setup(16'hFFFF, 16'h0001, 4'd0);
    runOp("add_carry", 0, '0, -1);
    requestOut("add_carry_const", {4'b1010, 16'h0000});
    setup(16'h0000, 16'h0000, 4'd1);
    runOp("adc", 0, '0, -1);
    requestOut("adc_const", {4'b0000, 16'h0001});

    // Latch on the start edge: the operation sees the old A.
    setup(16'h0100, 16'h0001, 4'd0);
    runOp("latch_with_start", 1, 16'h0F00, -1);
    runOp("after_latch_start", 0, '0, -1);

    // Reset in the middle of a shift.
    setup(16'hC000, 16'h000F, 4'd10);
    i_start = 1;
    tick();
    clearIn();
    tick(); tick();
    i_outputResult = 1;
    #2;
    i_Reset = 1;
    #1;
    check("midrst_data",  int'(o_data), 0);
    check("midrst_valid", int'(o_valid), 0);
    check("midrst_busy",  int'(o_busy), 0);
    check("midrst_done",  int'(o_done), 0);
    check("midrst_flags", int'(o_flags), 0);
    tick();
    clearIn();
    i_Reset = 0;
    mA = '0; mB = '0; mRes = '0; mOp = '0; mFlags = '0;
    tick();
    runOp("post_reset_add", 0, '0, -1);

    // Randomised operations.
    for (int i = 0; i < 60; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      rop = 4'($urandom_range(0, 15));
      order = $urandom_range(0, 2);
      if (order == 0) begin
        latch(1, 0, 1, 0, ra); latch(1, 0, 0, 1, rb); latch(1, 1, 0, 0, {12'h000, rop});
      end else if (order == 1) begin
        latch(1, 1, 0, 0, {12'h000, rop}); latch(1, 0, 0, 1, rb); latch(1, 0, 1, 0, ra);
      end else begin
        latch(1, 0, 0, 1, rb); latch(1, 1, 0, 0, {12'h000, rop}); latch(1, 0, 1, 0, ra);
      end
      runOp("rand", 0, '0, -1);
    end

    tick();
    check("sb_drained", sbQ.size(), 0);
    tick(); tick();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
